// File: rtl/aoi222_arc_sequencer.sv
// Walks all 54 conditional timing arcs of an aoi222 cell (6 pins x 9 side conditions),
// toggling each pin 0->1->0 and checking ZN after every settle window.
module aoi222_arc_sequencer #(
  parameter int SETTLE_CYC = 2,
  parameter int CNT_W      = 8
) (
  input  logic             CLK,
  input  logic             RN,
  input  logic             START,
  input  logic             ZN,
  output logic             A1,
  output logic             A2,
  output logic             B1,
  output logic             B2,
  output logic             C1,
  output logic             C2,
  output logic             BUSY,
  output logic             DONE,
  output logic [2:0]       ARC_PIN,
  output logic [3:0]       ARC_COND,
  output logic [CNT_W-1:0] ERR_CNT,
  output logic             FAIL,
  output logic [2:0]       FAIL_PIN,
  output logic [3:0]       FAIL_COND
);
  localparam int PH_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_HI, S_LO, S_DONE} state_t;

  state_t          r_state;
  logic [PH_W-1:0] r_ph;
  logic [2:0]      r_pin;
  logic [3:0]      r_cond;
  logic [5:0]      r_drv;   // {A1,A2,B1,B2,C1,C2}
  logic            r_busy, r_done, r_fail;
  logic [CNT_W-1:0] r_err;
  logic [2:0]      r_fpin;
  logic [3:0]      r_fcond;

  logic       w_end, w_exp, w_mis, w_last;
  logic [2:0] w_npin;
  logic [3:0] w_ncond;

  // Side-pair code: 0->(0,0) 1->(0,1) 2->(1,0); (1,1) would mask the arc.
  function automatic logic [1:0] side_code(input logic [1:0] c);
    side_code = (c == 2'd1) ? 2'b01 : (c == 2'd2) ? 2'b10 : 2'b00;
  endfunction

  function automatic logic [5:0] drive(input logic [2:0] pin, input logic [3:0] cond,
                                       input logic tv);
    logic [1:0] ci, cj, px, py, pt;
    logic [3:0] rem;
    rem = cond;
    if (rem >= 4'd6) begin ci = 2'd2; rem = rem - 4'd6; end
    else if (rem >= 4'd3) begin ci = 2'd1; rem = rem - 4'd3; end
    else ci = 2'd0;
    cj = rem[1:0];
    px = side_code(ci);
    py = side_code(cj);
    pt = pin[0] ? {1'b1, tv} : {tv, 1'b1};
    case (pin[2:1])
      2'd0:    drive = {pt, px, py};
      2'd1:    drive = {px, pt, py};
      default: drive = {px, py, pt};
    endcase
  endfunction

  assign w_end   = (r_ph == PH_W'(SETTLE_CYC - 1));
  assign w_exp   = (r_state != S_HI);
  assign w_mis   = (ZN !== w_exp);
  assign w_last  = (r_pin == 3'd5) && (r_cond == 4'd8);
  assign w_ncond = (r_cond == 4'd8) ? 4'd0 : r_cond + 4'd1;
  assign w_npin  = (r_cond == 4'd8) ? r_pin + 3'd1 : r_pin;

  always_ff @(posedge CLK) begin
    if (!RN) begin
      r_state <= S_IDLE;
      r_ph    <= '0;
      r_pin   <= '0;
      r_cond  <= '0;
      r_drv   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_fail  <= 1'b0;
      r_err   <= '0;
      r_fpin  <= '0;
      r_fcond <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: if (START) begin
          r_state <= S_PRE;
          r_busy  <= 1'b1;
          r_ph    <= '0;
          r_pin   <= '0;
          r_cond  <= '0;
          r_drv   <= drive(3'd0, 4'd0, 1'b0);
          r_err   <= '0;
          r_fail  <= 1'b0;
          r_fpin  <= '0;
          r_fcond <= '0;
        end
        S_PRE, S_HI, S_LO: begin
          if (!w_end) begin
            r_ph <= r_ph + PH_W'(1);
          end else begin
            r_ph <= '0;
            if (w_mis) begin
              if (r_err != '1) r_err <= r_err + CNT_W'(1);
              if (!r_fail) begin
                r_fail  <= 1'b1;
                r_fpin  <= r_pin;
                r_fcond <= r_cond;
              end
            end
            if (r_state == S_PRE) begin
              r_state <= S_HI;
              r_drv   <= drive(r_pin, r_cond, 1'b1);
            end else if (r_state == S_HI) begin
              r_state <= S_LO;
              r_drv   <= drive(r_pin, r_cond, 1'b0);
            end else if (w_last) begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_drv   <= '0;
            end else begin
              r_state <= S_PRE;
              r_pin   <= w_npin;
              r_cond  <= w_ncond;
              r_drv   <= drive(w_npin, w_ncond, 1'b0);
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_pin   <= '0;
          r_cond  <= '0;
        end
      endcase
    end
  end

  assign {A1, A2, B1, B2, C1, C2} = r_drv;
  assign BUSY      = r_busy;
  assign DONE      = r_done;
  assign ARC_PIN   = r_pin;
  assign ARC_COND  = r_cond;
  assign ERR_CNT   = r_err;
  assign FAIL      = r_fail;
  assign FAIL_PIN  = r_fpin;
  assign FAIL_COND = r_fcond;
endmodule
